// File: rtl/uart_cmd_sequencer.sv
// Plays a byte script from a small RAM to a UART transmitter, then optionally collects a response up to EOL or timeout.
// One byte per accept plus a one-cycle gap; stalls in SEND while i_tx_busy is high; no backpressure on rx.
module uart_cmd_sequencer #(
  parameter int         NBYTES    = 16,
  parameter int         TIMEOUT   = 65535,
  parameter logic [7:0] EOL       = 8'h0A,
  parameter bit         WAIT_RESP = 1'b1,
  localparam int        AW        = $clog2(NBYTES),
  localparam int        LW        = $clog2(NBYTES + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [LW-1:0] i_len,
  input  logic          i_start,
  output logic          o_tx_stb,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy,
  input  logic          i_rx_stb,
  input  logic [7:0]    i_rx_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [7:0]    o_resp_count,
  output logic [7:0]    o_resp_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_RESP,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    ram [NBYTES];
  logic [AW-1:0] idx;
  logic [LW-1:0] len;
  logic [LW-1:0] len_clip;
  logic [15:0]   timer;
  logic          last_byte;
  logic          timed_out;

  assign len_clip  = (i_len > LW'(NBYTES)) ? LW'(NBYTES) : i_len;
  assign last_byte = ((LW'(idx) + LW'(1)) == len);
  assign timed_out = (timer == 16'(TIMEOUT));

  // Script RAM has no reset so a script survives an aborted run.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && state == S_IDLE) begin
      ram[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = (i_len == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (!i_tx_busy) begin
          if (!last_byte) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = WAIT_RESP ? S_RESP : S_DONE;
          end
        end
      end
      S_GAP: state_nxt = S_SEND;
      S_RESP: begin
        if (i_rx_stb) begin
          if (i_rx_data == EOL) begin
            state_nxt = S_DONE;
          end
        end else if (timed_out) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_stb  = 1'b0;
    o_tx_data = 8'h00;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      S_IDLE: o_busy = 1'b0;
      S_SEND: begin
        o_tx_stb  = 1'b1;
        o_tx_data = ram[idx];
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // An rx byte in the same cycle as the timeout wins: it restarts the idle window.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      idx          <= '0;
      len          <= '0;
      timer        <= '0;
      o_error      <= 1'b0;
      o_resp_count <= 8'h00;
      o_resp_last  <= 8'h00;
    end else begin
      if (state == S_RESP && !i_rx_stb) begin
        timer <= timer + 16'd1;
      end else begin
        timer <= '0;
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            len          <= len_clip;
            idx          <= '0;
            o_error      <= 1'b0;
            o_resp_count <= 8'h00;
            o_resp_last  <= 8'h00;
          end
        end
        S_GAP: idx <= idx + 1'b1;
        S_RESP: begin
          if (i_rx_stb) begin
            o_resp_last <= i_rx_data;
            if (o_resp_count != 8'hFF) begin
              o_resp_count <= o_resp_count + 8'd1;
            end
          end else if (timed_out) begin
            o_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized scoreboard bench: expected tx bytes and done records are queued by the stimulus and popped by a negedge monitor.
module tb_uart_cmd_sequencer;

  typedef struct packed {
    logic       err;
    logic [7:0] cnt;
    logic [7:0] last;
  } done_t;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_wr_en;
  logic [3:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic [4:0] i_len;
  logic       i_start;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_rx_stb;
  logic [7:0] i_rx_data;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [7:0] o_resp_count;
  logic [7:0] o_resp_last;

  uart_cmd_sequencer #(
    .NBYTES   (16),
    .TIMEOUT  (100),
    .EOL      (8'h0A),
    .WAIT_RESP(1'b1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_len       (i_len),
    .i_start     (i_start),
    .o_tx_stb    (o_tx_stb),
    .o_tx_data   (o_tx_data),
    .i_tx_busy   (i_tx_busy),
    .i_rx_stb    (i_rx_stb),
    .i_rx_data   (i_rx_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_resp_count(o_resp_count),
    .o_resp_last (o_resp_last)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         acc_count = 0;
  int         done_count = 0;
  int         last_acc_cyc = 0;
  int         done_cyc = 0;
  int         start_cyc = 0;
  bit         force_busy = 1'b0;
  logic [7:0] ram_m [16];
  logic [7:0] exp_tx [$];
  done_t      exp_done [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every accepted tx byte and every done pulse is matched against the queues.
  always @(negedge clk) begin
    if (i_reset === 1'b1) begin
      if (o_tx_stb && !i_tx_busy) begin
        acc_count++;
        last_acc_cyc = cyc;
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", {24'h0, o_tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_tx.pop_front()});
        end
      end
      if (o_done) begin
        done_count++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          check("done_unexpected", 32'(o_done), 32'h0);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          check("done_err", 32'(o_error), 32'(e.err));
          check("done_cnt", 32'(o_resp_count), 32'(e.cnt));
          check("done_last", 32'(o_resp_last), 32'(e.last));
        end
      end
    end
  end

  // UART transmitter model: busy for 10 clocks after each accept.
  initial begin
    int seen;
    int busy_cnt;
    seen = 0;
    busy_cnt = 0;
    i_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_count != seen) begin
        seen = acc_count;
        busy_cnt = 10;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      i_tx_busy = force_busy || (busy_cnt > 0);
    end
  end

  task automatic wr(input int addr, input logic [7:0] data, input bit model);
    @(posedge clk);
    #1;
    i_wr_en = 1'b1;
    i_wr_addr = 4'(addr);
    i_wr_data = data;
    if (model) ram_m[addr] = data;
    @(posedge clk);
    #1;
    i_wr_en = 1'b0;
  endtask

  task automatic do_start(input int len);
    int n;
    @(posedge clk);
    #1;
    n = (len > 16) ? 16 : len;
    for (int k = 0; k < n; k++) exp_tx.push_back(ram_m[k]);
    i_len = 5'(len);
    i_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk);
    #1;
    i_rx_stb = 1'b1;
    i_rx_data = b;
    @(posedge clk);
    #1;
    i_rx_stb = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (acc_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(acc_count >= target), 32'h1);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(done_count >= target), 32'h1);
  endtask

  task automatic push_done(input logic err, input logic [7:0] cnt, input logic [7:0] last);
    done_t d;
    d.err = err;
    d.cnt = cnt;
    d.last = last;
    exp_done.push_back(d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] script [6];
    logic [7:0] hold;
    logic [7:0] b;
    int a0;
    int d0;
    int unstable;
    script = '{8'h41, 8'h32, 8'h30, 8'h34, 8'h30, 8'h52};
    i_reset = 1'b0;
    i_wr_en = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_len = '0;
    i_start = 1'b0;
    i_rx_stb = 1'b0;
    i_rx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_tx_stb", 32'(o_tx_stb), 32'h0);
    check("rst_tx_data", 32'(o_tx_data), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_error", 32'(o_error), 32'h0);
    check("rst_count", 32'(o_resp_count), 32'h0);
    check("rst_last", 32'(o_resp_last), 32'h0);
    @(posedge clk);
    #1;
    i_reset = 1'b1;

    // Six-byte script, response "K\n"; an early EOL during SEND must be ignored.
    for (int k = 0; k < 16; k++) wr(k, 8'($urandom_range(0, 255)), 1'b1);
    for (int k = 0; k < 6; k++) wr(k, script[k], 1'b1);
    a0 = acc_count;
    d0 = done_count;
    do_start(6);
    wait_acc(a0 + 2, 200, "basic_acc2");
    send_rx(8'h0A);
    wait_acc(a0 + 6, 300, "basic_acc6");
    push_done(1'b0, 8'd2, 8'h0A);
    send_rx(8'h4B);
    send_rx(8'h0A);
    wait_done(d0 + 1, 50, "basic_done");
    repeat (5) @(negedge clk);
    #1;
    check("basic_done_pulses", 32'(done_count), 32'(d0 + 1));
    check("basic_idle", 32'(o_busy), 32'h0);
    check("basic_hold_last", 32'(o_resp_last), 32'h0A);

    // Silent line: timeout 100 => done 101 clocks after RESP entry.
    a0 = acc_count;
    d0 = done_count;
    push_done(1'b1, 8'd0, 8'd0);
    do_start(2);
    wait_acc(a0 + 2, 100, "tmo_acc");
    wait_done(d0 + 1, 200, "tmo_done");
    check("tmo_latency", 32'(done_cyc - last_acc_cyc), 32'd102);

    // Transmitter stalled for 50 clocks.
    force_busy = 1'b1;
    a0 = acc_count;
    d0 = done_count;
    do_start(3);
    @(negedge clk);
    #1;
    check("stall_stb", 32'(o_tx_stb), 32'h1);
    hold = o_tx_data;
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (!o_tx_stb || o_tx_data !== hold) unstable++;
    end
    check("stall_stable", 32'(unstable), 32'h0);
    check("stall_data", 32'(hold), 32'(ram_m[0]));
    check("stall_no_acc", 32'(acc_count), 32'(a0));
    force_busy = 1'b0;
    wait_acc(a0 + 1, 5, "stall_release");
    repeat (5) @(negedge clk);
    #1;
    check("stall_single_acc", 32'(acc_count), 32'(a0 + 1));
    wait_acc(a0 + 3, 100, "stall_acc3");
    push_done(1'b0, 8'd2, 8'h0A);
    send_rx(8'h55);
    send_rx(8'h0A);
    wait_done(d0 + 1, 50, "stall_done");

    // Reset pulse while the third byte is pending.
    a0 = acc_count;
    d0 = done_count;
    do_start(6);
    wait_acc(a0 + 2, 200, "rst_acc2");
    force_busy = 1'b1;
    for (int n = 0; n < 20 && !o_tx_stb; n++) begin
      @(negedge clk);
      #1;
    end
    check("rst_third_pending", 32'(o_tx_stb), 32'h1);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    exp_tx.delete();
    check("rst_abort_stb", 32'(o_tx_stb), 32'h0);
    check("rst_abort_busy", 32'(o_busy), 32'h0);
    force_busy = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("rst_no_done", 32'(done_count), 32'(d0));
    a0 = acc_count;
    do_start(6);
    wait_acc(a0 + 6, 300, "rst_resend");
    push_done(1'b0, 8'd1, 8'h0A);
    send_rx(8'h0A);
    wait_done(d0 + 1, 50, "rst_done");

    // Zero-length start, then an over-long length clipped to the RAM depth.
    a0 = acc_count;
    d0 = done_count;
    push_done(1'b0, 8'd0, 8'd0);
    do_start(0);
    wait_done(d0 + 1, 5, "len0_done");
    check("len0_latency_ok", 32'((done_cyc - start_cyc) <= 2), 32'h1);
    check("len0_no_tx", 32'(acc_count), 32'(a0));
    for (int k = 0; k < 16; k++) wr(k, 8'($urandom_range(0, 255)), 1'b1);
    a0 = acc_count;
    d0 = done_count;
    do_start(20);
    wait_acc(a0 + 16, 400, "len20_acc");
    push_done(1'b0, 8'd1, 8'h0A);
    send_rx(8'h0A);
    wait_done(d0 + 1, 50, "len20_done");
    check("len20_count", 32'(acc_count), 32'(a0 + 16));

    // Start and RAM write while busy are ignored; 300 bytes saturate the count.
    a0 = acc_count;
    d0 = done_count;
    do_start(4);
    wait_acc(a0 + 1, 50, "busy_acc1");
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_len = 5'd1;
    i_wr_en = 1'b1;
    i_wr_addr = 4'd0;
    i_wr_data = ~ram_m[0];
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_wr_en = 1'b0;
    wait_acc(a0 + 4, 200, "busy_acc4");
    b = 8'h00;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      b = 8'($urandom_range(0, 255));
      if (b == 8'h0A) b = 8'h0B;
      i_rx_stb = 1'b1;
      i_rx_data = b;
    end
    push_done(1'b1, 8'd255, b);
    @(posedge clk);
    #1;
    i_rx_stb = 1'b0;
    wait_done(d0 + 1, 300, "sat_done");
    repeat (5) @(negedge clk);
    #1;
    check("sat_hold_count", 32'(o_resp_count), 32'd255);
    check("sat_hold_error", 32'(o_error), 32'h1);
    check("busy_no_restart", 32'(acc_count), 32'(a0 + 4));
    a0 = acc_count;
    d0 = done_count;
    do_start(4);
    wait_acc(a0 + 4, 200, "ram_kept_acc");
    push_done(1'b0, 8'd1, 8'h0A);
    send_rx(8'h0A);
    wait_done(d0 + 1, 50, "ram_kept_done");

    repeat (5) @(negedge clk);
    #1;
    check("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
    check("done_queue_drained", 32'(exp_done.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
